// File: rtl/mbc5_pkg.sv
// mbc5_pkg: shared MBC5 register map, region bases and sequencer enums.
package mbc5_pkg;
  localparam logic [15:0] REG_RAMEN = 16'h0000;
  localparam logic [15:0] REG_ROMB = 16'h2000;
  localparam logic [15:0] REG_RAMB = 16'h4000;
  localparam logic [15:0] ROMX_BASE = 16'h4000;
  localparam logic [15:0] SRAM_BASE = 16'hA000;
  localparam logic [7:0] RAM_ENABLE_KEY = 8'h0A;
  typedef enum logic [1:0] {STEP_ENW, STEP_RBW, STEP_BANKW, STEP_ACCESS} step_e;
  typedef enum logic [1:0] {S_IDLE, S_PLAN, S_CYCLE, S_RESP} state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} phase_e;
  function automatic logic is_sram(input logic [15:0] a);
    return a[15:13] == 3'b101;
  endfunction
endpackage

// File: rtl/gb_bus_cycle.sv
// gb_bus_cycle: one timed cartridge bus cycle (setup / strobe / hold).
// A start on the done clock chains the next cycle with no idle gap.
module gb_bus_cycle
  import mbc5_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_write,
  output logic        o_done,
  output logic [7:0]  o_rdata,
  output logic [15:0] o_cart_addr,
  output logic [7:0]  o_cart_dout,
  output logic        o_cart_doe,
  input  logic [7:0]  i_cart_din,
  output logic        o_cart_rd_n,
  output logic        o_cart_wr_n,
  output logic        o_cart_cs_n
);
  localparam logic [7:0] SU = 8'(SETUP_CYC - 1);
  localparam logic [7:0] ST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HD = 8'(HOLD_CYC - 1);
  phase_e r_phase;
  logic [7:0] r_cnt;
  logic r_write;
  logic w_last, w_busy;
  assign w_last = r_cnt == 8'd0;
  assign w_busy = r_phase != PH_IDLE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_phase <= PH_IDLE;
      r_cnt <= 8'd0;
      r_write <= 1'b0;
      o_cart_addr <= 16'h0000;
      o_cart_dout <= 8'h00;
      o_rdata <= 8'h00;
    end else begin
      if (r_phase == PH_STROBE && w_last && !r_write) o_rdata <= i_cart_din;
      if (i_start) begin
        r_phase <= PH_SETUP;
        r_cnt <= SU;
        r_write <= i_write;
        o_cart_addr <= i_addr;
        o_cart_dout <= i_wdata;
      end else if (w_busy) begin
        r_cnt <= w_last ? (r_phase == PH_SETUP ? ST : HD) : r_cnt - 8'd1;
        if (w_last) r_phase <= r_phase == PH_SETUP ? PH_STROBE : r_phase == PH_STROBE ? PH_HOLD : PH_IDLE;
      end
    end
  end
  assign o_done = r_phase == PH_HOLD && w_last;
  assign o_cart_doe = w_busy && r_write;
  assign o_cart_cs_n = !(w_busy && is_sram(o_cart_addr));
  assign o_cart_rd_n = !(r_phase == PH_STROBE && !r_write);
  assign o_cart_wr_n = !(r_phase == PH_STROBE && r_write);
endmodule

// File: rtl/mbc5_bus_sequencer.sv
// mbc5_bus_sequencer: turns linear ROM/FRAM byte requests into MBC5 register
// writes plus the data access, skipping writes the bank cache proves redundant.
module mbc5_bus_sequencer
  import mbc5_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_ram,
  input  logic        req_write,
  input  logic [20:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        invalidate,
  output logic [15:0] cart_addr,
  output logic [7:0]  cart_dout,
  output logic        cart_doe,
  input  logic [7:0]  cart_din,
  output logic        cart_rd_n,
  output logic        cart_wr_n,
  output logic        cart_cs_n
);
  state_e r_state, w_next;
  logic r_ram, r_write;
  logic [20:0] r_addr;
  logic [7:0] r_wdata;
  logic [5:0] r_steps, w_plan;
  logic [1:0] r_left, w_plan_left;
  logic [6:0] r_rom_bank;
  logic [1:0] r_ram_bank;
  logic r_rom_vld, r_ram_vld, r_ram_en;
  logic w_done, w_start, w_write, w_rom_hi, w_rb_miss;
  logic [7:0] w_rdata, w_wdata;
  logic [15:0] w_addr, w_acc_addr;
  step_e w_cur, w_sstep;
  assign w_rom_hi = r_addr[20:14] != 7'd0;
  assign w_rb_miss = !r_ram_vld || r_ram_bank != r_addr[14:13];
  assign w_cur = step_e'(r_steps[1:0]);
  // Steps are queued low-first; the current step always sits in bits [1:0].
  always_comb begin
    w_plan = {STEP_ACCESS, STEP_ACCESS, STEP_ACCESS};
    w_plan_left = 2'd0;
    if (!r_ram) begin
      if (w_rom_hi && (!r_rom_vld || r_rom_bank != r_addr[20:14])) begin
        w_plan[1:0] = STEP_BANKW;
        w_plan_left = 2'd1;
      end
    end else if (!r_ram_en) begin
      w_plan[1:0] = STEP_ENW;
      w_plan[3:2] = w_rb_miss ? STEP_RBW : STEP_ACCESS;
      w_plan_left = w_rb_miss ? 2'd2 : 2'd1;
    end else if (w_rb_miss) begin
      w_plan[1:0] = STEP_RBW;
      w_plan_left = 2'd1;
    end
  end
  assign w_start = r_state == S_PLAN || (r_state == S_CYCLE && w_done && r_left != 2'd0);
  assign w_sstep = r_state == S_PLAN ? step_e'(w_plan[1:0]) : step_e'(r_steps[3:2]);
  assign w_acc_addr = r_ram ? (SRAM_BASE | {3'b000, r_addr[12:0]}) :
                      w_rom_hi ? (ROMX_BASE | {2'b00, r_addr[13:0]}) : {2'b00, r_addr[13:0]};
  always_comb begin
    w_addr = w_sstep == STEP_ENW ? REG_RAMEN : w_sstep == STEP_RBW ? REG_RAMB :
             w_sstep == STEP_BANKW ? REG_ROMB : w_acc_addr;
    w_wdata = w_sstep == STEP_ENW ? RAM_ENABLE_KEY : w_sstep == STEP_RBW ? {6'b0, r_addr[14:13]} :
              w_sstep == STEP_BANKW ? {1'b0, r_addr[20:14]} : r_wdata;
    w_write = w_sstep != STEP_ACCESS || r_write;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = req_valid ? S_PLAN : S_IDLE;
      S_PLAN: w_next = S_CYCLE;
      S_CYCLE: w_next = (w_done && r_left == 2'd0) ? S_RESP : S_CYCLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    req_ready = r_state == S_IDLE;
    rsp_valid = r_state == S_RESP;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ram <= 1'b0;
      r_write <= 1'b0;
      r_addr <= 21'd0;
      r_wdata <= 8'h00;
      r_steps <= 6'd0;
      r_left <= 2'd0;
      r_rom_bank <= 7'd0;
      r_ram_bank <= 2'd0;
      r_rom_vld <= 1'b0;
      r_ram_vld <= 1'b0;
      r_ram_en <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_ram <= req_ram;
        r_write <= req_write;
        r_addr <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_PLAN) begin
        r_steps <= w_plan;
        r_left <= w_plan_left;
      end else if (w_start) begin
        r_steps <= {2'b00, r_steps[5:2]};
        r_left <= r_left - 2'd1;
      end
      if (r_state == S_CYCLE && w_done && r_left == 2'd0 && !r_write) rsp_rdata <= w_rdata;
      if (invalidate) begin
        r_rom_vld <= 1'b0;
        r_ram_vld <= 1'b0;
        r_ram_en <= 1'b0;
      end else if (r_state == S_CYCLE && w_done) begin
        if (w_cur == STEP_ENW) r_ram_en <= 1'b1;
        if (w_cur == STEP_RBW) begin
          r_ram_bank <= r_addr[14:13];
          r_ram_vld <= 1'b1;
        end
        if (w_cur == STEP_BANKW) begin
          r_rom_bank <= r_addr[20:14];
          r_rom_vld <= 1'b1;
        end
      end
    end
  end
  gb_bus_cycle #(.SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC)) u_cyc (
    .clock(clock), .reset(reset), .i_start(w_start), .i_addr(w_addr), .i_wdata(w_wdata),
    .i_write(w_write), .o_done(w_done), .o_rdata(w_rdata), .o_cart_addr(cart_addr),
    .o_cart_dout(cart_dout), .o_cart_doe(cart_doe), .i_cart_din(cart_din),
    .o_cart_rd_n(cart_rd_n), .o_cart_wr_n(cart_wr_n), .o_cart_cs_n(cart_cs_n)
  );
endmodule

// File: tb/tb_mbc5_bus_sequencer.sv
// tb_mbc5_bus_sequencer: two sequencers (default and 2/1/2 timing) on modelled
// cartridges; each request is checked clock-by-clock against the expected cycle list.
module tb_mbc5_bus_sequencer;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid[2], req_ram[2], req_write[2], invalidate[2];
  logic [20:0] req_addr[2];
  logic [7:0] req_wdata[2], rsp_rdata[2], cart_dout[2], cart_din[2];
  logic req_ready[2], rsp_valid[2], cart_doe[2], cart_rd_n[2], cart_wr_n[2], cart_cs_n[2];
  logic [15:0] cart_addr[2];
  int checks = 0, errors = 0;
  always #5 clock = ~clock;

  mbc5_bus_sequencer u0 (
    .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_ram(req_ram[0]), .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .invalidate(invalidate[0]),
    .cart_addr(cart_addr[0]), .cart_dout(cart_dout[0]), .cart_doe(cart_doe[0]), .cart_din(cart_din[0]),
    .cart_rd_n(cart_rd_n[0]), .cart_wr_n(cart_wr_n[0]), .cart_cs_n(cart_cs_n[0])
  );
  mbc5_bus_sequencer #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(2)) u1 (
    .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_ram(req_ram[1]), .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .invalidate(invalidate[1]),
    .cart_addr(cart_addr[1]), .cart_dout(cart_dout[1]), .cart_doe(cart_doe[1]), .cart_din(cart_din[1]),
    .cart_rd_n(cart_rd_n[1]), .cart_wr_n(cart_wr_n[1]), .cart_cs_n(cart_cs_n[1])
  );

  function automatic int su(input int i); return i == 0 ? 1 : 2; endfunction
  function automatic int st(input int i); return i == 0 ? 3 : 1; endfunction
  function automatic int ln(input int i); return i == 0 ? 5 : 5; endfunction
  function automatic logic [7:0] rom_byte(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[20:14]} ^ 8'h5C;
  endfunction

  // Cartridge model: MBC5 bank registers, FRAM on instance 0, ROM contents from rom_byte.
  logic [6:0] c_rb[2] = '{7'd0, 7'd0};
  logic [1:0] c_qb = 2'd0;
  logic [7:0] cf[int];
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!cart_wr_n[i]) begin
        if (cart_addr[i][15:12] == 4'h2) c_rb[i] = cart_dout[i][6:0];
        if (i == 0 && cart_addr[i][15:13] == 3'b010) c_qb = cart_dout[i][1:0];
        if (i == 0 && !cart_cs_n[i]) cf[int'({c_qb, cart_addr[i][12:0]})] = cart_dout[i];
      end
      if (i == 0 && !cart_cs_n[i])
        cart_din[i] = cf.exists(int'({c_qb, cart_addr[i][12:0]})) ? cf[int'({c_qb, cart_addr[i][12:0]})] : 8'hFF;
      else
        cart_din[i] = rom_byte(cart_addr[i][14] ? {c_rb[i], cart_addr[i][13:0]} : {7'd0, cart_addr[i][13:0]});
    end
  end

  // Reference model: what the sequencer should believe about the cartridge.
  bit m_rv[2], m_qv[2], m_en[2];
  logic [6:0] m_rb[2];
  logic [1:0] m_qb[2];
  logic [7:0] last_rd[2];
  logic [7:0] m_fram[int];
  logic [15:0] s_addr[100];
  logic [7:0] s_dout[100];
  logic s_rd[100], s_wr[100], s_cs[100], s_doe[100], s_ready[100];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = 0; m_qv[i] = 0; m_en[i] = 0; last_rd[i] = 8'h00;
    end
  endtask

  task automatic inv(input int i);
    invalidate[i] = 1'b1;
    @(posedge clock); #1;
    invalidate[i] = 1'b0;
    m_rv[i] = 0; m_qv[i] = 0; m_en[i] = 0;
  endtask

  task automatic run(input int i, input bit ram, input bit wr, input logic [20:0] a, input logic [7:0] d, input bit hold);
    logic [15:0] ea[3];
    logic [7:0] ed[3];
    bit ew[3];
    logic [7:0] exp_rd;
    int n = 0, rt = 0, bad, tt;
    bit sb;
    if (!ram) begin
      if (a[20:14] != 7'd0) begin
        if (!m_rv[i] || m_rb[i] != a[20:14]) begin ea[n] = 16'h2000; ed[n] = {1'b0, a[20:14]}; ew[n] = 1; n++; end
        ea[n] = 16'h4000 | {2'b00, a[13:0]};
        m_rv[i] = 1; m_rb[i] = a[20:14];
      end else ea[n] = {2'b00, a[13:0]};
      ed[n] = d; ew[n] = wr; n++;
      exp_rd = rom_byte(a);
    end else begin
      if (!m_en[i]) begin ea[n] = 16'h0000; ed[n] = 8'h0A; ew[n] = 1; n++; end
      if (!m_qv[i] || m_qb[i] != a[14:13]) begin ea[n] = 16'h4000; ed[n] = {6'd0, a[14:13]}; ew[n] = 1; n++; end
      ea[n] = 16'hA000 | {3'b000, a[12:0]}; ed[n] = d; ew[n] = wr; n++;
      m_en[i] = 1; m_qv[i] = 1; m_qb[i] = a[14:13];
      exp_rd = m_fram.exists(int'(a[14:0])) ? m_fram[int'(a[14:0])] : 8'hFF;
      if (wr) m_fram[int'(a[14:0])] = d;
    end
    req_ram[i] = ram; req_write[i] = wr; req_addr[i] = a; req_wdata[i] = d; req_valid[i] = 1'b1;
    check("accept_ready", 32'(req_ready[i]), 1);
    @(posedge clock); #1;
    for (int t = 1; t < 100; t++) begin
      s_addr[t] = cart_addr[i]; s_dout[t] = cart_dout[i]; s_rd[t] = cart_rd_n[i]; s_wr[t] = cart_wr_n[i];
      s_cs[t] = cart_cs_n[i]; s_doe[t] = cart_doe[i]; s_ready[t] = req_ready[i];
      if (t == 1 && !hold) req_valid[i] = 1'b0;
      if (rsp_valid[i]) begin rt = t; break; end
      @(posedge clock); #1;
    end
    req_valid[i] = 1'b0;
    check("latency", rt, 2 + n * ln(i));
    check("busy_ready", 32'(s_ready[1]), 0);
    for (int k = 0; k < n; k++) begin
      bad = 0;
      for (int o = 0; o < ln(i); o++) begin
        tt = 2 + k * ln(i) + o;
        sb = o >= su(i) && o < su(i) + st(i);
        if (tt < 100) begin
          if (s_addr[tt] !== ea[k]) bad++;
          if (s_rd[tt] !== !(sb && !ew[k])) bad++;
          if (s_wr[tt] !== !(sb && ew[k])) bad++;
          if (s_cs[tt] !== !(ea[k][15:13] == 3'b101)) bad++;
          if (s_doe[tt] !== ew[k]) bad++;
          if (ew[k] && s_dout[tt] !== ed[k]) bad++;
        end
      end
      check($sformatf("cyc%0d_addr", k), 32'(s_addr[2 + k * ln(i) + su(i)]), 32'(ea[k]));
      check($sformatf("cyc%0d_pins", k), bad, 0);
    end
    if (!wr) begin
      check("rdata", 32'(rsp_rdata[i]), 32'(exp_rd));
      last_rd[i] = exp_rd;
    end else check("rdata_kept", 32'(rsp_rdata[i]), 32'(last_rd[i]));
    @(posedge clock); #1;
    check("ready_after", 32'(req_ready[i]), 1);
    check("rsp_pulse", 32'(rsp_valid[i]), 0);
    if (hold) begin
      bad = 0;
      repeat (6) begin
        if (!cart_rd_n[i] || !cart_wr_n[i] || !req_ready[i] || rsp_valid[i]) bad++;
        @(posedge clock); #1;
      end
      check("no_reaccept", bad, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_ram[i] = 0; req_write[i] = 0; req_addr[i] = 0; req_wdata[i] = 0; invalidate[i] = 0;
    end
    clear_model();
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(req_ready[0]), 1);
    check("rst_rsp_valid", 32'(rsp_valid[0]), 0);
    check("rst_rdata", 32'(rsp_rdata[0]), 0);
    check("rst_addr", 32'(cart_addr[0]), 0);
    check("rst_dout", 32'(cart_dout[0]), 0);
    check("rst_pins", {28'd0, cart_doe[0], cart_rd_n[0], cart_wr_n[0], cart_cs_n[0]}, 32'h7);
    reset = 1'b0;
    @(posedge clock); #1;
    run(0, 0, 0, 21'h00123, 8'h00, 0);
    run(0, 0, 0, 21'h1F4005, 8'h00, 0);
    run(0, 0, 0, 21'h1F4006, 8'h00, 0);
    run(0, 1, 1, 21'h006ABC, 8'h5A, 0);
    run(0, 1, 1, 21'h006ABC, 8'h5A, 0);
    inv(0);
    run(0, 1, 0, 21'h006ABC, 8'h00, 0);
    run(0, 0, 1, 21'h000AAA, 8'hAA, 0);
    // abort a bank write in the middle of its strobe
    req_ram[0] = 0; req_write[0] = 0; req_addr[0] = 21'h0A8000; req_valid[0] = 1'b1;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    check("abort_strobe_low", 32'(cart_wr_n[0]), 0);
    check("abort_bank_addr", 32'(cart_addr[0]), 32'h2000);
    reset = 1'b1;
    #1;
    check("abort_pins", {28'd0, cart_doe[0], cart_rd_n[0], cart_wr_n[0], cart_cs_n[0]}, 32'h7);
    check("abort_ready", 32'(req_ready[0]), 1);
    @(posedge clock); #1;
    reset = 1'b0;
    clear_model();
    run(0, 0, 0, 21'h0A8000, 8'h00, 0);
    run(1, 0, 0, 21'h0A1234, 8'h00, 1);
    run(1, 0, 0, 21'h0A1235, 8'h00, 1);
    for (int r = 0; r < 40; r++) begin
      logic [6:0] bk;
      bit ram;
      ram = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: bk = 7'd0;
        1: bk = 7'h7F;
        default: bk = 7'($urandom_range(1, 3));
      endcase
      if (ram) run(0, 1, $urandom_range(0, 1) == 1, {6'($urandom), 2'($urandom_range(0, 3)), 13'($urandom_range(0, 7))}, 8'($urandom), 0);
      else run(0, 0, 0, {bk, 14'($urandom)}, 8'h00, 0);
      if ($urandom_range(0, 9) == 0) inv(0);
    end
    for (int r = 0; r < 15; r++) run(1, 0, 0, {7'($urandom_range(0, 3)), 14'($urandom)}, 8'h00, $urandom_range(0, 1) == 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
